// File: rtl/envase_ctrl.sv
// Bottle filling/corking line controller: sensor sync + debounce, six-state sequencer.
// Latency: sensor edge to state change is 2 sync + DEB_CYCLES + 1 cycles; all outputs registered.
// Backpressure: none; inputs are level signals and the pulses are single-cycle strobes.
//
// Ports:
//   clk, reset      - system clock (rising edge) and asynchronous active-low reset
//   start           - run enable (level)
//   sensor          - raw bottle-present sensor, asynchronous to clk
//   full_level      - bottle full (synchronous)
//   cork_empty      - cork dispenser stock is zero (synchronous)
//   alarm_ack       - operator acknowledge (synchronous)
//   motor/valve/seal/alarm - registered actuator and fault outputs
//   bottle_done     - one-cycle pulse per finished bottle
//   cork_use        - one-cycle pulse per cork consumed
//   state           - current state code
module envase_ctrl #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter logic [7:0]  FILL_MAX    = 8'd200,
  parameter logic [7:0]  SEAL_CYCLES = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sensor,
  input  logic       full_level,
  input  logic       cork_empty,
  input  logic       alarm_ack,
  output logic       motor,
  output logic       valve,
  output logic       seal,
  output logic       bottle_done,
  output logic       cork_use,
  output logic       alarm,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MOVE  = 3'd1,
    FILL  = 3'd2,
    SEAL  = 3'd3,
    EJECT = 3'd4,
    ALARM = 3'd5
  } state_e;

  localparam logic [3:0] DEB_LAST  = 4'(DEB_CYCLES - 1);
  localparam logic [7:0] FILL_LAST = FILL_MAX - 8'd1;
  localparam logic [7:0] SEAL_LAST = SEAL_CYCLES - 8'd1;

  logic       sync1_q, sync2_q;
  logic       sens_db_q, sens_db_d;
  logic       sens_prev_q;
  logic [3:0] db_cnt_q, db_cnt_d;
  state_e     state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic       nocork_q, nocork_d;
  logic       motor_q, valve_q, seal_q, bottle_done_q, cork_use_q, alarm_q;
  logic       motor_d, valve_d, seal_d, bottle_done_d, cork_use_d, alarm_d;
  logic       db_rise;

  // Debounce: the count only advances while the synchronized level disagrees
  // with the accepted level; any agreement (a bounce back) clears it.
  always_comb begin
    db_cnt_d  = '0;
    sens_db_d = sens_db_q;
    if (sync2_q != sens_db_q) begin
      if (db_cnt_q == DEB_LAST) begin
        sens_db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 4'd1;
      end
    end
  end

  assign db_rise = sens_db_q & ~sens_prev_q;

  always_comb begin
    state_d  = state_q;
    nocork_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cork_empty) state_d = MOVE;
      end
      MOVE: begin
        // A new bottle wins over a stop request in the same cycle.
        if (db_rise)     state_d = FILL;
        else if (!start) state_d = IDLE;
      end
      FILL: begin
        if (full_level) begin
          state_d  = SEAL;
          // Cork stock is judged at SEAL entry; an empty dispenser makes the
          // SEAL visit a single dead cycle on the way to ALARM.
          nocork_d = cork_empty;
        end else if (tmr_q == FILL_LAST) begin
          state_d = ALARM;
        end
      end
      SEAL: begin
        if (nocork_q)                state_d = ALARM;
        else if (tmr_q == SEAL_LAST) state_d = EJECT;
        nocork_d = nocork_q;
      end
      EJECT: begin
        // Level test also releases a bottle that left during SEAL.
        if (!sens_db_q) state_d = start ? MOVE : IDLE;
      end
      ALARM: begin
        if (alarm_ack && !cork_empty) state_d = IDLE;
      end
      default: state_d = ALARM;
    endcase
  end

  // Timer restarts on every state change so FILL and SEAL each see 0 on entry.
  always_comb begin
    tmr_d = '0;
    if (state_d == state_q && (state_q == FILL || state_q == SEAL)) begin
      tmr_d = tmr_q + 8'd1;
    end
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they line up with the state code of the same cycle.
  always_comb begin
    motor_d       = (state_d == MOVE) || (state_d == EJECT);
    valve_d       = (state_d == FILL);
    seal_d        = (state_d == SEAL) && !nocork_d;
    alarm_d       = (state_d == ALARM);
    cork_use_d    = (state_d == SEAL) && !nocork_d && (tmr_d == SEAL_LAST);
    bottle_done_d = (state_q == EJECT) && (state_d != EJECT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sens_db_q     <= 1'b0;
      sens_prev_q   <= 1'b0;
      db_cnt_q      <= '0;
      state_q       <= IDLE;
      tmr_q         <= '0;
      nocork_q      <= 1'b0;
      motor_q       <= 1'b0;
      valve_q       <= 1'b0;
      seal_q        <= 1'b0;
      bottle_done_q <= 1'b0;
      cork_use_q    <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      sync1_q       <= sensor;
      sync2_q       <= sync1_q;
      sens_db_q     <= sens_db_d;
      sens_prev_q   <= sens_db_q;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      nocork_q      <= nocork_d;
      motor_q       <= motor_d;
      valve_q       <= valve_d;
      seal_q        <= seal_d;
      bottle_done_q <= bottle_done_d;
      cork_use_q    <= cork_use_d;
      alarm_q       <= alarm_d;
    end
  end

  assign motor       = motor_q;
  assign valve       = valve_q;
  assign seal        = seal_q;
  assign bottle_done = bottle_done_q;
  assign cork_use    = cork_use_q;
  assign alarm       = alarm_q;
  assign state       = state_q;

endmodule

// File: tb/tb_envase_ctrl.sv
module tb_envase_ctrl;
  localparam int DEB  = 4;
  localparam int FMAX = 200;
  localparam int SCYC = 20;
  // Sensor change to visible state change: 2 synchronizer flops, DEB stable
  // cycles, one registered-output cycle.
  localparam int SENS_LAT = DEB + 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MOVE  = 3'd1;
  localparam logic [2:0] ST_FILL  = 3'd2;
  localparam logic [2:0] ST_SEAL  = 3'd3;
  localparam logic [2:0] ST_EJECT = 3'd4;
  localparam logic [2:0] ST_ALARM = 3'd5;

  logic clk = 1'b0;
  logic reset, start, sensor, full_level, cork_empty, alarm_ack;
  logic motor, valve, seal, bottle_done, cork_use, alarm;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int n_done = 0, n_cork = 0, n_seal = 0, n_overlap = 0;

  always #5 clk = ~clk;

  envase_ctrl #(
    .DEB_CYCLES (DEB),
    .FILL_MAX   (8'(FMAX)),
    .SEAL_CYCLES(8'(SCYC))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sensor     (sensor),
    .full_level (full_level),
    .cork_empty (cork_empty),
    .alarm_ack  (alarm_ack),
    .motor      (motor),
    .valve      (valve),
    .seal       (seal),
    .bottle_done(bottle_done),
    .cork_use   (cork_use),
    .alarm      (alarm),
    .state      (state)
  );

  // Advance one cycle, sample on the falling edge and tally pulses.
  task automatic tick();
    @(negedge clk);
    if (bottle_done) n_done++;
    if (cork_use) n_cork++;
    if (seal) n_seal++;
    if (bottle_done && cork_use) n_overlap++;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int took, output bit ok);
    took = 0;
    ok = 1'b0;
    while (took < budget) begin
      tick();
      took++;
      if (state === s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got=%0d exp=0", state);
    end
    checks++;
    if ({motor, valve, seal, bottle_done, cork_use, alarm} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=000000", {motor, valve, seal, bottle_done, cork_use, alarm});
    end
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (state !== ST_IDLE || motor !== 1'b0) begin
      errors++; $display("FAIL reset_idle_hold state=%0d motor=%b exp state=0 motor=0", state, motor);
    end
  endtask

  // One complete bottle; expectations are the cycle counts the behaviour implies.
  task automatic test_normal(input int fill_dly, input int ej_dly, input bit drop, input string tag);
    int took; bit ok; int d0, c0, o0, n, cork_pos; bit bad;
    logic [2:0] exp_end;
    start = 1'b1; cork_empty = 1'b0; full_level = 1'b0; sensor = 1'b0; alarm_ack = 1'b0;
    wait_state(ST_MOVE, 5, took, ok);
    checks++;
    if (!ok || motor !== 1'b1) begin
      errors++; $display("FAIL %s move got state=%0d motor=%b exp state=1 motor=1", tag, state, motor);
    end
    d0 = n_done; c0 = n_cork; o0 = n_overlap;
    sensor = 1'b1;
    wait_state(ST_FILL, 40, took, ok);
    checks++;
    if (!ok || took != SENS_LAT) begin
      errors++; $display("FAIL %s fill_latency got=%0d ok=%0d exp=%0d", tag, took, ok, SENS_LAT);
    end
    checks++;
    if (valve !== 1'b1 || motor !== 1'b0) begin
      errors++; $display("FAIL %s fill_outputs valve=%b motor=%b exp valve=1 motor=0", tag, valve, motor);
    end
    if (drop) start = 1'b0;
    bad = 1'b0;
    for (int i = 1; i < fill_dly; i++) begin
      tick();
      if (state !== ST_FILL || valve !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL %s fill_hold got state=%0d exp=2 for %0d cycles", tag, state, fill_dly);
    end
    full_level = 1'b1;
    tick();
    full_level = 1'b0;
    n = 0; cork_pos = 0; bad = 1'b0;
    while (state === ST_SEAL && n < 300) begin
      n++;
      if (cork_use) cork_pos = n;
      if (seal !== 1'b1) bad = 1'b1;
      tick();
    end
    checks++;
    if (n != SCYC || bad) begin
      errors++; $display("FAIL %s seal_len got=%0d gap=%0d exp=%0d", tag, n, bad, SCYC);
    end
    checks++;
    if (cork_pos != SCYC) begin
      errors++; $display("FAIL %s cork_pos got=%0d exp=%0d", tag, cork_pos, SCYC);
    end
    checks++;
    if (state !== ST_EJECT || motor !== 1'b1) begin
      errors++; $display("FAIL %s eject got state=%0d motor=%b exp state=4 motor=1", tag, state, motor);
    end
    bad = 1'b0;
    for (int i = 0; i < ej_dly; i++) begin
      tick();
      if (state !== ST_EJECT) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL %s eject_hold got state=%0d exp=4", tag, state);
    end
    sensor = 1'b0;
    exp_end = drop ? ST_IDLE : ST_MOVE;
    wait_state(exp_end, 40, took, ok);
    checks++;
    if (!ok || took != SENS_LAT) begin
      errors++; $display("FAIL %s eject_exit got=%0d state=%0d exp=%0d state=%0d", tag, took, state, SENS_LAT, exp_end);
    end
    checks++;
    if (bottle_done !== 1'b1) begin
      errors++; $display("FAIL %s done_pulse got=%b exp=1", tag, bottle_done);
    end
    tick();
    checks++;
    if (bottle_done !== 1'b0) begin
      errors++; $display("FAIL %s done_width got=%b exp=0", tag, bottle_done);
    end
    checks++;
    if (n_done - d0 != 1 || n_cork - c0 != 1 || n_overlap != o0) begin
      errors++; $display("FAIL %s pulse_counts done=%0d cork=%0d overlap=%0d exp 1 1 0", tag, n_done - d0, n_cork - c0, n_overlap - o0);
    end
  endtask

  task automatic test_bounce();
    int took; bit ok; bit bad;
    start = 1'b1; cork_empty = 1'b0; full_level = 1'b0; sensor = 1'b0;
    wait_state(ST_MOVE, 5, took, ok);
    bad = !ok;
    for (int i = 0; i < 10; i++) begin
      sensor = (i % 2 == 0);
      repeat (2) begin
        tick();
        if (state !== ST_MOVE) bad = 1'b1;
      end
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bounce_hold got state=%0d exp=1", state);
    end
    sensor = 1'b1;
    wait_state(ST_FILL, 40, took, ok);
    checks++;
    if (!ok || took != SENS_LAT) begin
      errors++; $display("FAIL bounce_fill_latency got=%0d ok=%0d exp=%0d", took, ok, SENS_LAT);
    end
    full_level = 1'b1;
    wait_state(ST_EJECT, 40, took, ok);
    full_level = 1'b0;
    sensor = 1'b0;
    wait_state(ST_MOVE, 40, took, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bounce_finish got state=%0d exp=1", state);
    end
  endtask

  task automatic test_fill_timeout();
    int took; bit ok; int n;
    start = 1'b1; cork_empty = 1'b0; full_level = 1'b0; sensor = 1'b0; alarm_ack = 1'b0;
    wait_state(ST_MOVE, 5, took, ok);
    sensor = 1'b1;
    wait_state(ST_FILL, 40, took, ok);
    n = 0;
    while (state === ST_FILL && n < 400) begin
      n++;
      tick();
    end
    checks++;
    if (n != FMAX) begin
      errors++; $display("FAIL timeout_fill_cycles got=%0d exp=%0d", n, FMAX);
    end
    checks++;
    if (state !== ST_ALARM || valve !== 1'b0 || alarm !== 1'b1 || motor !== 1'b0) begin
      errors++; $display("FAIL timeout_alarm state=%0d valve=%b alarm=%b motor=%b exp 5 0 1 0", state, valve, alarm, motor);
    end
    start = 1'b0; sensor = 1'b0;
    repeat (8) tick();
    checks++;
    if (state !== ST_ALARM) begin
      errors++; $display("FAIL timeout_alarm_hold got=%0d exp=5", state);
    end
    alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;
    checks++;
    if (state !== ST_IDLE || alarm !== 1'b0) begin
      errors++; $display("FAIL timeout_ack state=%0d alarm=%b exp state=0 alarm=0", state, alarm);
    end
  endtask

  task automatic test_cork_empty();
    int took; bit ok; bit bad; int s0, c0;
    start = 1'b1; cork_empty = 1'b0; full_level = 1'b0; sensor = 1'b0; alarm_ack = 1'b0;
    wait_state(ST_MOVE, 5, took, ok);
    sensor = 1'b1;
    wait_state(ST_FILL, 40, took, ok);
    s0 = n_seal; c0 = n_cork;
    cork_empty = 1'b1;
    full_level = 1'b1;
    wait_state(ST_ALARM, 5, took, ok);
    full_level = 1'b0;
    start = 1'b0;
    checks++;
    if (!ok || alarm !== 1'b1) begin
      errors++; $display("FAIL cork_alarm got state=%0d alarm=%b exp state=5 alarm=1", state, alarm);
    end
    checks++;
    if (n_seal != s0 || n_cork != c0) begin
      errors++; $display("FAIL cork_no_seal seal_cycles=%0d cork_use=%0d exp 0 0", n_seal - s0, n_cork - c0);
    end
    alarm_ack = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (state !== ST_ALARM) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL cork_ack_blocked got state=%0d exp=5", state);
    end
    cork_empty = 1'b0;
    tick();
    alarm_ack = 1'b0;
    checks++;
    if (state !== ST_IDLE) begin
      errors++; $display("FAIL cork_ack_release got=%0d exp=0", state);
    end
    sensor = 1'b0;
    repeat (DEB + 4) tick();
  endtask

  task automatic test_reset_mid_seal();
    int took; bit ok; int d0, c0;
    start = 1'b1; cork_empty = 1'b0; full_level = 1'b0; sensor = 1'b0; alarm_ack = 1'b0;
    wait_state(ST_MOVE, 5, took, ok);
    sensor = 1'b1;
    wait_state(ST_FILL, 40, took, ok);
    full_level = 1'b1;
    wait_state(ST_SEAL, 3, took, ok);
    full_level = 1'b0;
    repeat (9) tick();
    checks++;
    if (state !== ST_SEAL || seal !== 1'b1) begin
      errors++; $display("FAIL rst_seal_setup got state=%0d seal=%b exp 3 1", state, seal);
    end
    d0 = n_done; c0 = n_cork;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (state !== ST_IDLE || {motor, valve, seal, bottle_done, cork_use, alarm} !== 6'b0) begin
      errors++; $display("FAIL rst_async state=%0d outs=%b exp 0 000000", state, {motor, valve, seal, bottle_done, cork_use, alarm});
    end
    start = 1'b0; sensor = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (SCYC + 5) tick();
    checks++;
    if (state !== ST_IDLE || n_done != d0 || n_cork != c0) begin
      errors++; $display("FAIL rst_no_pulses state=%0d done=%0d cork=%0d exp 0 0 0", state, n_done - d0, n_cork - c0);
    end
    start = 1'b1;
    tick();
    checks++;
    if (state !== ST_MOVE) begin
      errors++; $display("FAIL rst_resume got=%0d exp=1", state);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sensor = 1'b0; full_level = 1'b0;
    cork_empty = 1'b0; alarm_ack = 1'b0;
    #2 reset = 1'b0;
    tick();
    tick();
    test_reset();
    test_normal(30, 5, 1'b0, "normal");
    test_bounce();
    test_normal(40, 8, 1'b1, "start_drop");
    test_fill_timeout();
    test_cork_empty();
    for (int k = 0; k < 5; k++) begin
      test_normal(int'($urandom_range(1, 150)), int'($urandom_range(0, 20)),
                  1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end
    test_reset_mid_seal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog state=%0d", state);
    $fatal(1, "watchdog expired");
  end

endmodule
